// File: rtl/hc04_exerciser.sv
// Clocked stimulus/response exerciser for a 74HC04 hex inverter: walks 8 patterns,
// samples the outputs after SETTLE_CYCLES and accumulates mismatch statistics.
module hc04_exerciser #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [5:0] drv,
  input  logic [5:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [5:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] drv_q, drv_d;
  logic [2:0] step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [5:0] mask_q, mask_d;
  logic [5:0] mism;
  logic       cmp_edge;

  function automatic logic [5:0] pattern(input logic [2:0] s);
    case (s)
      3'd0:    pattern = 6'b000000;
      3'd7:    pattern = 6'b111111;
      default: pattern = 6'b000001 << (s - 3'd1);
    endcase
  endfunction

  // Case equality so an unknown output bit counts as a mismatch, not a silent pass.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 6; i++)
      mism[i] = (y[i] === ~drv_q[i]) ? 1'b0 : 1'b1;
  end

  assign cmp_edge = (cnt_q == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drv_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drv_d   = drv_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE, DONE: begin
        drv_d = '0;
        if (start) begin
          state_d = RUN;
          drv_d   = pattern(3'd0);
          step_d  = '0;
          cnt_d   = '0;
          err_d   = '0;
          mask_d  = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cmp_edge) begin
          if (mism != 6'd0) err_d = err_q + 4'd1;
          mask_d = mask_q | mism;
          if (step_q != 3'd7) begin
            step_d = step_q + 3'd1;
            drv_d  = pattern(step_q + 3'd1);
            cnt_d  = '0;
          end else begin
            state_d = DONE;
            drv_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    pass      = done && (err_q == 4'd0);
    drv       = drv_q;
    err_count = err_q;
    fail_mask = mask_q;
  end

endmodule

// File: tb/tb_hc04_exerciser.sv
// Bench for hc04_exerciser: two instances (settle 2 and 1) driving a modelled
// inverter with injectable stuck-at faults, checked against a pattern-level model.
module tb_hc04_exerciser;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [5:0] drv1, y1, drv2, y2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [3:0] err1, err2;
  logic [5:0] mask1, mask2;
  logic [5:0] s0, s1;
  logic       noninv;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0] pat [8] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F};

  always #5 clk = ~clk;

  // Faulty-inverter model: stuck-at-0 mask s0, stuck-at-1 mask s1, or buffer wiring.
  function automatic logic [5:0] inv_model(input logic [5:0] a);
    if (noninv) return a;
    return (~a & ~s0) | s1;
  endfunction

  assign y1 = inv_model(drv1);
  assign y2 = inv_model(drv2);

  hc04_exerciser u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .drv(drv1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  hc04_exerciser #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .drv(drv2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from a 1-cycle start pulse; repulse_t >= 0 re-pulses start after that edge.
  task automatic run(input string nm, input int repulse_t);
    int         e_err;
    logic [5:0] e_mask, m, act;
    e_err = 0;
    e_mask = '0;
    for (int k = 0; k < 8; k++) begin
      act = noninv ? pat[k] : ((~pat[k] & ~s0) | s1);
      m = act ^ ~pat[k];
      if (m != 6'd0) e_err++;
      e_mask |= m;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, ":clr_err"}, err1, 0);
    chk({nm, ":clr_mask"}, mask1, 0);
    for (int t = 0; t < 16; t++) begin
      chk({nm, ":drv1"}, drv1, pat[t / 2]);
      chk({nm, ":busy1"}, {busy1, done1}, 2'b10);
      if (t < 8) chk({nm, ":drv2"}, drv2, pat[t]);
      if (t == 8) begin
        chk({nm, ":done2"}, {busy2, done2, drv2}, {2'b01, 6'h00});
        chk({nm, ":err2"}, err2, e_err);
        chk({nm, ":mask2"}, mask2, e_mask);
        chk({nm, ":pass2"}, pass2, (e_err == 0));
      end
      start = (t == repulse_t);
      tick();
      start = 1'b0;
    end
    chk({nm, ":done1"}, {busy1, done1, drv1}, {2'b01, 6'h00});
    chk({nm, ":err1"}, err1, e_err);
    chk({nm, ":mask1"}, mask1, e_mask);
    chk({nm, ":pass1"}, pass1, (e_err == 0));
    repeat (3) tick();
    chk({nm, ":hold"}, {done1, err1, mask1}, {1'b1, 4'(e_err), e_mask});
    repeat (8) tick();
  endtask

  initial begin
    s0 = '0; s1 = '0; noninv = 1'b0;
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("rst1", {busy1, done1, pass1, err1, mask1, drv1}, '0);
    chk("rst2", {busy2, done2, pass2, err2, mask2, drv2}, '0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle", {busy1, done1, drv1}, '0);

    run("good", -1);
    run("good_again", -1);
    s0 = 6'b000100;
    run("y3_sa0", -1);
    s0 = '0;
    noninv = 1'b1;
    run("noninv", -1);
    noninv = 1'b0;
    run("repulse", 9);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid_drv", drv1, pat[3]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst1", {busy1, done1, pass1, err1, mask1, drv1}, '0);
    chk("midrst2", {busy2, done2, pass2, err2, mask2, drv2}, '0);
    run("after_rst", -1);

    for (int r = 0; r < 6; r++) begin
      s0 = 6'($urandom);
      s1 = 6'($urandom) & ~s0;
      run("rand", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
